// File: rtl/gpu_mem_pkg.sv
// Shared memory-side constants and helpers for the GPU page-table-walk path.
package gpu_mem_pkg;

    localparam int PA_BITS       = 48;
    localparam int PTE_BITS      = 64;
    localparam int PTW_REQ_MMU   = 0;
    localparam int PTW_REQ_IOMMU = 1;

    // Index width for N requesters; never narrower than one bit.
    function automatic int req_idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ptw_id_fifo.sv
// Count-based synchronous FIFO used to remember which requester owns each in-order return.
module ptw_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ptw_port_arbiter.sv
// Round-robin share of the page-table-walk read port; returns are routed in issue order.
module ptw_port_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int N_REQ           = 2,
    parameter int PA_BITS         = gpu_mem_pkg::PA_BITS,
    parameter int DATA_BITS       = gpu_mem_pkg::PTE_BITS,
    parameter int MAX_OUTSTANDING = 4,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req_ar_valid,
    output logic [N_REQ-1:0]                req_ar_ready,
    input  logic [N_REQ-1:0][PA_BITS-1:0]   req_ar_addr,
    output logic [N_REQ-1:0]                req_r_valid,
    input  logic [N_REQ-1:0]                req_r_ready,
    output logic [DATA_BITS-1:0]            req_r_data,
    output logic                            mem_ar_valid,
    input  logic                            mem_ar_ready,
    output logic [PA_BITS-1:0]              mem_ar_addr,
    input  logic                            mem_r_valid,
    output logic                            mem_r_ready,
    input  logic [DATA_BITS-1:0]            mem_r_data,
    output logic [OW-1:0]                   outstanding,
    output logic                            stray_r
);

    localparam int IW = req_idx_w(N_REQ);

    logic [IW-1:0] rr_r;
    logic          lock_r;
    logic [IW-1:0] lock_idx_r;
    logic [IW-1:0] rr_pick_s;
    logic          rr_found_s;
    logic [IW-1:0] grant_s;
    logic          any_s;
    logic          ar_hs_s;
    logic          r_hs_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [IW-1:0] fifo_head_s;

    // Grant selection: a stalled grant stays frozen while its owner keeps valid high.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        rr_pick_s  = {IW{1'b0}};
        rr_found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_v = (int'(rr_r) + i) % N_REQ;
            if (!rr_found_s && req_ar_valid[IW'(idx_v)]) begin
                rr_found_s = 1'b1;
                rr_pick_s  = IW'(idx_v);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        if (lock_r && req_ar_valid[lock_idx_r]) begin
            grant_s = lock_idx_r;
            any_s   = 1'b1;
        end else begin
            grant_s = rr_pick_s;
            any_s   = rr_found_s;
        end
    end

    assign mem_ar_valid = any_s && !fifo_full_s;
    assign ar_hs_s      = mem_ar_valid && mem_ar_ready;
    assign r_hs_s       = mem_r_valid && mem_r_ready;
    assign req_r_data   = mem_r_data;

    // AR address mux and per-walker ready.
    always_comb begin
        req_ar_ready = {N_REQ{1'b0}};
        if (any_s) begin
            mem_ar_addr = req_ar_addr[grant_s];
        end else begin
            mem_ar_addr = {PA_BITS{1'b0}};
        end
        if (ar_hs_s) begin
            req_ar_ready[grant_s] = 1'b1;
        end else begin
            req_ar_ready = {N_REQ{1'b0}};
        end
    end

    // Return routing to the walker at the FIFO head; stray beats are never accepted.
    always_comb begin
        req_r_valid = {N_REQ{1'b0}};
        mem_r_ready = 1'b0;
        if (!fifo_empty_s) begin
            req_r_valid[fifo_head_s] = mem_r_valid;
            mem_r_ready              = req_r_ready[fifo_head_s];
        end else begin
            mem_r_ready = 1'b0;
        end
    end

    // Round-robin pointer, grant lock and sticky stray flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r       <= {IW{1'b0}};
            lock_r     <= 1'b0;
            lock_idx_r <= {IW{1'b0}};
            stray_r    <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                rr_r   <= (grant_s == IW'(N_REQ - 1)) ? {IW{1'b0}} : grant_s + IW'(1);
                lock_r <= 1'b0;
            end else if (mem_ar_valid) begin
                lock_r     <= 1'b1;
                lock_idx_r <= grant_s;
            end else begin
                lock_r <= 1'b0;
            end
            stray_r <= stray_r | (mem_r_valid && fifo_empty_s);
        end
    end

    ptw_id_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs_s),
        .push_data (grant_s),
        .pop       (r_hs_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (outstanding),
        .head      (fifo_head_s)
    );

endmodule

// File: tb/tb_ptw_port_arbiter.sv
// Directed scenario bench for ptw_port_arbiter with hand-computed expectations.
module tb_ptw_port_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_ar_valid;
    logic [1:0]        req_ar_ready;
    logic [1:0][47:0]  req_ar_addr;
    logic [1:0]        req_r_valid;
    logic [1:0]        req_r_ready;
    logic [63:0]       req_r_data;
    logic              mem_ar_valid;
    logic              mem_ar_ready;
    logic [47:0]       mem_ar_addr;
    logic              mem_r_valid;
    logic              mem_r_ready;
    logic [63:0]       mem_r_data;
    logic [2:0]        outstanding;
    logic              stray_r;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [47:0] A0 = 48'h0000_0000_2000;
    localparam logic [47:0] A1 = 48'h0000_0000_3000;

    ptw_port_arbiter #(
        .N_REQ(2), .PA_BITS(48), .DATA_BITS(64), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready), .req_ar_addr(req_ar_addr),
        .req_r_valid(req_r_valid), .req_r_ready(req_r_ready), .req_r_data(req_r_data),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
        .outstanding(outstanding), .stray_r(stray_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_ar_valid = 2'b00; req_ar_addr = '0; req_r_ready = 2'b00;
        mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = 64'h0;
        #3;
        total_cnt++; if (mem_ar_valid !== 1'b0) $display("FAIL rst_mem_ar_valid got %b exp 0", mem_ar_valid); else pass_cnt++;
        total_cnt++; if (req_ar_ready !== 2'b00) $display("FAIL rst_req_ar_ready got %b exp 00", req_ar_ready); else pass_cnt++;
        total_cnt++; if (req_r_valid !== 2'b00) $display("FAIL rst_req_r_valid got %b exp 00", req_r_valid); else pass_cnt++;
        total_cnt++; if (mem_r_ready !== 1'b0) $display("FAIL rst_mem_r_ready got %b exp 0", mem_r_ready); else pass_cnt++;
        total_cnt++; if (mem_ar_addr !== 48'h0) $display("FAIL rst_mem_ar_addr got %h exp 0", mem_ar_addr); else pass_cnt++;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding got %0d exp 0", outstanding); else pass_cnt++;
        total_cnt++; if (stray_r !== 1'b0) $display("FAIL rst_stray got %b exp 0", stray_r); else pass_cnt++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        req_r_ready = 2'b11; req_ar_addr[1] = 48'h0000_1000_0040; req_ar_valid = 2'b10; mem_ar_ready = 1'b1;
        #1;
        total_cnt++; if (mem_ar_valid !== 1'b1) $display("FAIL single_ar_valid got %b exp 1", mem_ar_valid); else pass_cnt++;
        total_cnt++; if (mem_ar_addr !== 48'h0000_1000_0040) $display("FAIL single_ar_addr got %h exp 10000040", mem_ar_addr); else pass_cnt++;
        total_cnt++; if (req_ar_ready !== 2'b10) $display("FAIL single_ar_ready got %b exp 10", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b00;
        #1;
        total_cnt++; if (outstanding !== 3'd1) $display("FAIL single_outst_1 got %0d exp 1", outstanding); else pass_cnt++;
        tick();
        tick();
        mem_r_valid = 1'b1; mem_r_data = 64'hABCD;
        #1;
        total_cnt++; if (req_r_valid !== 2'b10) $display("FAIL single_r_valid got %b exp 10", req_r_valid); else pass_cnt++;
        total_cnt++; if (req_r_data !== 64'hABCD) $display("FAIL single_r_data got %h exp abcd", req_r_data); else pass_cnt++;
        total_cnt++; if (mem_r_ready !== 1'b1) $display("FAIL single_r_ready got %b exp 1", mem_r_ready); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL single_outst_0 got %0d exp 0", outstanding); else pass_cnt++;
        total_cnt++; if (req_r_valid !== 2'b00) $display("FAIL single_r_idle got %b exp 00", req_r_valid); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0] exp_v;
        req_ar_addr[0] = A0; req_ar_addr[1] = A1;
        tick();
        req_ar_valid = 2'b11; mem_ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_v = (k % 2 == 0) ? 2'b01 : 2'b10;
            total_cnt++; if (req_ar_ready !== exp_v) $display("FAIL cont_grant%0d got %b exp %b", k, req_ar_ready, exp_v); else pass_cnt++;
            total_cnt++; if (mem_ar_addr !== ((k % 2 == 0) ? A0 : A1)) $display("FAIL cont_addr%0d got %h", k, mem_ar_addr); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (outstanding !== 3'd4) $display("FAIL cont_full_outst got %0d exp 4", outstanding); else pass_cnt++;
        total_cnt++; if (mem_ar_valid !== 1'b0) $display("FAIL cont_full_blocked got %b exp 0", mem_ar_valid); else pass_cnt++;
        total_cnt++; if (req_ar_ready !== 2'b00) $display("FAIL cont_full_ready got %b exp 00", req_ar_ready); else pass_cnt++;
        req_ar_valid = 2'b00; mem_r_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_r_data = 64'(k + 1);
            #1;
            exp_v = (k % 2 == 0) ? 2'b01 : 2'b10;
            total_cnt++; if (req_r_valid !== exp_v) $display("FAIL cont_ret%0d got %b exp %b", k, req_r_valid, exp_v); else pass_cnt++;
            tick();
        end
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL cont_drain got %0d exp 0", outstanding); else pass_cnt++;
        req_ar_valid = 2'b11;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b01) $display("FAIL cont_rr_wrap got %b exp 01", req_ar_ready); else pass_cnt++;
        req_ar_valid = 2'b00;
        #1;
    endtask

    task automatic test_lock();
        tick();
        mem_ar_ready = 1'b0; req_ar_valid = 2'b10;
        #1;
        total_cnt++; if (mem_ar_addr !== A1) $display("FAIL lock_first_addr got %h exp %h", mem_ar_addr, A1); else pass_cnt++;
        tick();
        req_ar_valid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++; if (mem_ar_addr !== A1) $display("FAIL lock_hold_addr%0d got %h exp %h", c, mem_ar_addr, A1); else pass_cnt++;
            total_cnt++; if (req_ar_ready !== 2'b00) $display("FAIL lock_hold_ready%0d got %b exp 00", c, req_ar_ready); else pass_cnt++;
            tick();
        end
        mem_ar_ready = 1'b1;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b10) $display("FAIL lock_hs_ready got %b exp 10", req_ar_ready); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (mem_ar_addr !== A0) $display("FAIL lock_next_addr got %h exp %h", mem_ar_addr, A0); else pass_cnt++;
        total_cnt++; if (req_ar_ready !== 2'b01) $display("FAIL lock_next_ready got %b exp 01", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b00;
        #1;
        total_cnt++; if (outstanding !== 3'd2) $display("FAIL lock_outst got %0d exp 2", outstanding); else pass_cnt++;
        mem_r_valid = 1'b1;
        #1;
        total_cnt++; if (req_r_valid !== 2'b10) $display("FAIL lock_ret0 got %b exp 10", req_r_valid); else pass_cnt++;
        tick();
        total_cnt++; if (req_r_valid !== 2'b01) $display("FAIL lock_ret1 got %b exp 01", req_r_valid); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL lock_drain got %0d exp 0", outstanding); else pass_cnt++;
    endtask

    task automatic test_lock_release();
        mem_ar_ready = 1'b0; req_ar_valid = 2'b10;
        #1;
        total_cnt++; if (mem_ar_addr !== A1) $display("FAIL rel_lock_addr got %h exp %h", mem_ar_addr, A1); else pass_cnt++;
        tick();
        req_ar_valid = 2'b11;
        #1;
        total_cnt++; if (mem_ar_addr !== A1) $display("FAIL rel_hold_addr got %h exp %h", mem_ar_addr, A1); else pass_cnt++;
        tick();
        req_ar_valid = 2'b01; mem_ar_ready = 1'b1;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b01) $display("FAIL rel_ready got %b exp 01", req_ar_ready); else pass_cnt++;
        total_cnt++; if (mem_ar_addr !== A0) $display("FAIL rel_addr got %h exp %h", mem_ar_addr, A0); else pass_cnt++;
        tick();
        req_ar_valid = 2'b00;
        #1;
        total_cnt++; if (outstanding !== 3'd1) $display("FAIL rel_outst got %0d exp 1", outstanding); else pass_cnt++;
        mem_r_valid = 1'b1;
        #1;
        total_cnt++; if (req_r_valid !== 2'b01) $display("FAIL rel_ret got %b exp 01", req_r_valid); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL rel_drain got %0d exp 0", outstanding); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        req_ar_valid = 2'b01;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b01) $display("FAIL bp_issue0 got %b exp 01", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b10;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b10) $display("FAIL bp_issue1 got %b exp 10", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b01;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b01) $display("FAIL bp_issue2 got %b exp 01", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b00;
        #1;
        total_cnt++; if (outstanding !== 3'd3) $display("FAIL bp_outst3 got %0d exp 3", outstanding); else pass_cnt++;
        mem_r_valid = 1'b1; mem_r_data = 64'h100; req_r_ready = 2'b11;
        #1;
        total_cnt++; if (req_r_valid !== 2'b01) $display("FAIL bp_ret0_valid got %b exp 01", req_r_valid); else pass_cnt++;
        total_cnt++; if (req_r_data !== 64'h100) $display("FAIL bp_ret0_data got %h exp 100", req_r_data); else pass_cnt++;
        tick();
        mem_r_data = 64'h200; req_r_ready = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++; if (mem_r_ready !== 1'b0) $display("FAIL bp_stall_ready%0d got %b exp 0", c, mem_r_ready); else pass_cnt++;
            total_cnt++; if (req_r_valid !== 2'b10) $display("FAIL bp_stall_valid%0d got %b exp 10", c, req_r_valid); else pass_cnt++;
            tick();
        end
        req_r_ready = 2'b11;
        #1;
        total_cnt++; if (mem_r_ready !== 1'b1) $display("FAIL bp_resume_ready got %b exp 1", mem_r_ready); else pass_cnt++;
        total_cnt++; if (outstanding !== 3'd2) $display("FAIL bp_no_loss got %0d exp 2", outstanding); else pass_cnt++;
        tick();
        mem_r_data = 64'h300; req_ar_valid = 2'b10;
        #1;
        total_cnt++; if (req_r_valid !== 2'b01) $display("FAIL bp_ret2_valid got %b exp 01", req_r_valid); else pass_cnt++;
        total_cnt++; if (req_ar_ready !== 2'b10) $display("FAIL bp_simul_ar got %b exp 10", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b00;
        #1;
        total_cnt++; if (outstanding !== 3'd1) $display("FAIL bp_simul_outst got %0d exp 1", outstanding); else pass_cnt++;
        total_cnt++; if (req_r_valid !== 2'b10) $display("FAIL bp_simul_head got %b exp 10", req_r_valid); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL bp_drain got %0d exp 0", outstanding); else pass_cnt++;
    endtask

    task automatic test_stray_reset();
        mem_r_valid = 1'b1;
        #1;
        total_cnt++; if (mem_r_ready !== 1'b0) $display("FAIL stray_r_ready got %b exp 0", mem_r_ready); else pass_cnt++;
        total_cnt++; if (req_r_valid !== 2'b00) $display("FAIL stray_r_valid got %b exp 00", req_r_valid); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (stray_r !== 1'b1) $display("FAIL stray_set got %b exp 1", stray_r); else pass_cnt++;
        tick();
        total_cnt++; if (stray_r !== 1'b1) $display("FAIL stray_sticky got %b exp 1", stray_r); else pass_cnt++;
        req_ar_valid = 2'b11;
        tick();
        tick();
        req_ar_valid = 2'b00;
        #1;
        total_cnt++; if (outstanding !== 3'd2) $display("FAIL stray_inflight got %0d exp 2", outstanding); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL rst_mid_outst got %0d exp 0", outstanding); else pass_cnt++;
        total_cnt++; if (stray_r !== 1'b0) $display("FAIL rst_mid_stray got %b exp 0", stray_r); else pass_cnt++;
        tick();
        rst_n = 1'b1; mem_r_valid = 1'b1;
        #1;
        total_cnt++; if (mem_r_ready !== 1'b0) $display("FAIL post_rst_r_ready got %b exp 0", mem_r_ready); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (stray_r !== 1'b1) $display("FAIL post_rst_stray got %b exp 1", stray_r); else pass_cnt++;
        req_ar_valid = 2'b10;
        #1;
        total_cnt++; if (req_ar_ready !== 2'b10) $display("FAIL post_rst_ar got %b exp 10", req_ar_ready); else pass_cnt++;
        tick();
        req_ar_valid = 2'b00; mem_r_valid = 1'b1; mem_r_data = 64'h55;
        #1;
        total_cnt++; if (req_r_valid !== 2'b10) $display("FAIL post_rst_route got %b exp 10", req_r_valid); else pass_cnt++;
        total_cnt++; if (req_r_data !== 64'h55) $display("FAIL post_rst_data got %h exp 55", req_r_data); else pass_cnt++;
        tick();
        mem_r_valid = 1'b0;
        #1;
        total_cnt++; if (outstanding !== 3'd0) $display("FAIL post_rst_drain got %0d exp 0", outstanding); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_lock_release();
        test_backpressure();
        test_stray_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
